spi_responder: RTL

SPI_RESPONDER -- requirements
Module: spi_responder

---
 rtl/spi_responder.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_responder.sv
// SPI responder: a serial target on an asynchronous SPI link, bridged to
// byte-wide tx/rx FIFOs in the clk domain.
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   SPI_CLK, SPI_EN, SPI_MOSI   initiator signals (asynchronous to clk)
//   SPI_MISO                    registered serial data back to the initiator
//   tx_push, tx_data, tx_full   tx byte FIFO write side
//   rx_pop, rx_data, rx_empty   rx byte FIFO read side (rx_data registered)
//   busy                        frame in progress
//   rx_overflow, frame_error    sticky status flags, cleared only by rst
module spi_responder #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SPI_CLK,
  input  logic       SPI_EN,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  input  logic       tx_push,
  input  logic [7:0] tx_data,
  output logic       tx_full,
  input  logic       rx_pop,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       busy,
  output logic       rx_overflow,
  output logic       frame_error
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  // Input synchronizers; r_valid masks edges until the chains hold real samples
  logic [SYNC_STAGES-1:0] r_clk_sync, r_en_sync, r_mosi_sync;
  logic                   r_clk_prev, r_en_prev;
  logic [SYNC_STAGES:0]   r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync  <= '0;
      r_en_sync   <= '0;
      r_mosi_sync <= '0;
      r_clk_prev  <= 1'b0;
      r_en_prev   <= 1'b0;
      r_valid     <= '0;
    end else begin
      r_clk_sync  <= SYNC_STAGES'({r_clk_sync, SPI_CLK});
      r_en_sync   <= SYNC_STAGES'({r_en_sync, SPI_EN});
      r_mosi_sync <= SYNC_STAGES'({r_mosi_sync, SPI_MOSI});
      r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
      r_en_prev   <= r_en_sync[SYNC_STAGES-1];
      r_valid     <= (SYNC_STAGES+1)'({r_valid, 1'b1});
    end
  end

  logic w_sync_ok, w_clk_s, w_en_s, w_mosi_s;
  logic w_clk_rise, w_clk_fall, w_en_rise, w_en_fall;

  // Masking after reset keeps a frame that was already running from
  // looking like a fresh SPI_EN rising edge.
  assign w_sync_ok  = r_valid[SYNC_STAGES];
  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_en_s     = r_en_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_clk_rise = w_sync_ok &  w_clk_s & ~r_clk_prev;
  assign w_clk_fall = w_sync_ok & ~w_clk_s &  r_clk_prev;
  assign w_en_rise  = w_sync_ok &  w_en_s  & ~r_en_prev;
  assign w_en_fall  = w_sync_ok & ~w_en_s  &  r_en_prev;

  // tx FIFO
  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [PW-1:0] r_tx_wp, r_tx_rp;
  logic [CW-1:0] r_tx_cnt;
  logic          w_tx_empty, w_tx_pop_req, w_tx_do_pop, w_tx_do_push;
  logic [7:0]    w_tx_load;

  assign w_tx_empty   = (r_tx_cnt == '0);
  assign tx_full      = (r_tx_cnt == CW'(FIFO_DEPTH));
  assign w_tx_load    = w_tx_empty ? 8'hFF : r_tx_mem[r_tx_rp];
  assign w_tx_do_pop  = w_tx_pop_req & ~w_tx_empty;
  assign w_tx_do_push = tx_push & (~tx_full | w_tx_do_pop);

  always_ff @(posedge clk) begin
    if (w_tx_do_push) r_tx_mem[r_tx_wp] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_do_push) r_tx_wp <= r_tx_wp + PW'(1);
      if (w_tx_do_pop)  r_tx_rp <= r_tx_rp + PW'(1);
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_do_push) - CW'(w_tx_do_pop);
    end
  end

  // rx FIFO
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rx_wp, r_rx_rp;
  logic [CW-1:0] r_rx_cnt;
  logic          w_rx_full, w_rx_push_req, w_rx_do_pop, w_rx_do_push;
  logic [7:0]    w_rx_byte, r_rx_data;
  logic          r_ovf;

  assign rx_empty     = (r_rx_cnt == '0);
  assign w_rx_full    = (r_rx_cnt == CW'(FIFO_DEPTH));
  assign w_rx_do_pop  = rx_pop & ~rx_empty;
  assign w_rx_do_push = w_rx_push_req & (~w_rx_full | w_rx_do_pop);
  assign rx_data      = r_rx_data;
  assign rx_overflow  = r_ovf;

  always_ff @(posedge clk) begin
    if (w_rx_do_push) r_rx_mem[r_rx_wp] <= w_rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_rx_cnt  <= '0;
      r_rx_data <= 8'h00;
      r_ovf     <= 1'b0;
    end else begin
      if (w_rx_do_push) r_rx_wp <= r_rx_wp + PW'(1);
      if (w_rx_do_pop)  r_rx_rp <= r_rx_rp + PW'(1);
      if (rx_pop)       r_rx_data <= rx_empty ? 8'hFF : r_rx_mem[r_rx_rp];
      if (w_rx_push_req & ~w_rx_do_push) r_ovf <= 1'b1;
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_do_push) - CW'(w_rx_do_pop);
    end
  end

  // Frame FSM and shift datapath
  state_t     r_state, w_state_nxt;
  logic [7:0] r_tx_shift, w_tx_shift_nxt, r_rx_shift, w_rx_shift_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic       r_reload, w_reload_nxt, r_start_pend, w_start_pend_nxt;
  logic       r_miso, r_ferr, w_ferr_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tx_shift   <= 8'h00;
      r_rx_shift   <= 8'h00;
      r_bit_cnt    <= 3'd7;
      r_reload     <= 1'b0;
      r_start_pend <= 1'b0;
      r_miso       <= 1'b0;
      r_ferr       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tx_shift   <= w_tx_shift_nxt;
      r_rx_shift   <= w_rx_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_reload     <= w_reload_nxt;
      r_start_pend <= w_start_pend_nxt;
      // Built from next-state values so MISO tracks tx_shift[7] with no lag
      r_miso       <= (w_state_nxt == S_SHIFT) ? w_tx_shift_nxt[7] : 1'b0;
      if (w_ferr_set) r_ferr <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_tx_shift_nxt   = r_tx_shift;
    w_rx_shift_nxt   = r_rx_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_reload_nxt     = r_reload;
    w_start_pend_nxt = r_start_pend;
    w_tx_pop_req     = 1'b0;
    w_rx_push_req    = 1'b0;
    w_rx_byte        = {r_rx_shift[6:0], w_mosi_s};
    w_ferr_set       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_en_rise || r_start_pend) begin
          w_state_nxt      = S_SHIFT;
          w_start_pend_nxt = 1'b0;
          w_tx_shift_nxt   = w_tx_load;
          w_tx_pop_req     = 1'b1;
          w_bit_cnt_nxt    = 3'd7;
          w_rx_shift_nxt   = 8'h00;
          w_reload_nxt     = 1'b0;
        end
      end
      S_SHIFT: begin
        if (w_en_fall) begin
          w_state_nxt    = S_DONE;
          w_ferr_set     = (r_bit_cnt != 3'd7);
          w_rx_shift_nxt = 8'h00;
          w_bit_cnt_nxt  = 3'd7;
          w_reload_nxt   = 1'b0;
        end else if (w_clk_rise) begin
          w_rx_shift_nxt = w_rx_byte;
          if (r_bit_cnt == 3'd0) begin
            w_rx_push_req = 1'b1;
            w_reload_nxt  = 1'b1;
            w_bit_cnt_nxt = 3'd7;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt - 3'd1;
          end
        end else if (w_clk_fall) begin
          if (r_reload) begin
            w_tx_shift_nxt = w_tx_load;
            w_tx_pop_req   = 1'b1;
            w_reload_nxt   = 1'b0;
          end else begin
            w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
          end
        end
      end
      S_DONE: begin
        w_state_nxt      = S_IDLE;
        // A new frame starting here would otherwise be lost
        w_start_pend_nxt = r_start_pend | w_en_rise;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign SPI_MISO    = r_miso;
  assign busy        = (r_state != S_IDLE);
  assign frame_error = r_ferr;

endmodule
